// File: rtl/cfu_simd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : cfu_simd_pkg                                                   |
// | Brief     : Shared op encodings, lane geometry and stage-1 command type    |
// |             for the pipelined SIMD MAC CFU.                                |
// | Revision  : 1.0  initial pipelined release                                 |
// +----------------------------------------------------------------------------+
package cfu_simd_pkg;

  // Lane geometry: 4 packed int8 lanes per 32-bit word, 9-bit signed offset.
  localparam int LANE_W = 8;
  localparam int OFF_W  = 9;
  localparam int LANES  = 4;

  // Offset-adjusted activation, single lane product and 4-lane sum widths.
  localparam int ACT_W  = LANE_W + 2;
  localparam int PROD_W = ACT_W + LANE_W;
  localparam int SUM_W  = PROD_W + $clog2(LANES);

  // Op field is function_id[9:3].
  localparam int OP_W = 7;

  localparam logic [OP_W-1:0] OP_MAC4 = 7'd0;
  localparam logic [OP_W-1:0] OP_CLR  = 7'd1;
  localparam logic [OP_W-1:0] OP_WRF  = 7'd2;
  localparam logic [OP_W-1:0] OP_MAC1 = 7'd3;
  localparam logic [OP_W-1:0] OP_SETO = 7'd4;
  localparam logic [OP_W-1:0] OP_RDA  = 7'd5;
  localparam logic [OP_W-1:0] OP_RDS  = 7'd7;

  // Command as held in stage 1; sel is already reduced modulo NUM_ACC.
  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [2:0]      sel;
    logic [31:0]     a;
  } s1_cmd_t;

  // Map the raw 3-bit select onto the implemented accumulators.
  function automatic logic [2:0] acc_sel(input logic [2:0] raw, input int num_acc);
    return 3'(int'(raw) % num_acc);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cfu_dot4.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : cfu_dot4                                                       |
// | Brief     : Combinational 4-lane signed dot product                        |
// |             sum_i (sext(a.b[i]) + off) * sext(f.b[i]); single_lane keeps   |
// |             lane 0 only (MAC1).                                            |
// | Revision  : 1.0  initial pipelined release                                 |
// +----------------------------------------------------------------------------+
module cfu_dot4
  import cfu_simd_pkg::*;
(
  input  logic [LANES*LANE_W-1:0] a,
  input  logic [LANES*LANE_W-1:0] f,
  input  logic signed [OFF_W-1:0] off,
  input  logic                    single_lane,
  output logic signed [SUM_W-1:0] sum
);

  logic signed [PROD_W-1:0] w_term [LANES];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [LANE_W-1:0] w_a_b;
    logic signed [LANE_W-1:0] w_f_b;
    logic signed [ACT_W-1:0]  w_act;
    logic signed [PROD_W-1:0] w_prod;

    assign w_a_b  = a[l*LANE_W +: LANE_W];
    assign w_f_b  = f[l*LANE_W +: LANE_W];
    // Offset range is symmetric enough that a + off always fits 10 bits.
    assign w_act  = ACT_W'(w_a_b) + ACT_W'(off);
    assign w_prod = PROD_W'(w_act) * PROD_W'(w_f_b);
    assign w_term[l] = (single_lane && (l != 0)) ? '0 : w_prod;
  end

  // Sign-extend each lane product and add them up.
  always_comb begin
    sum = '0;
    for (int l = 0; l < LANES; l++) begin
      sum = sum + SUM_W'(w_term[l]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/cfu_simd_mac_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : cfu_simd_mac_pipe                                              |
// | Brief     : Pipelined 4-lane int8 SIMD MAC CFU with filter RAM, NUM_ACC    |
// |             accumulators, programmable input offset and readback.          |
// |             Stage 0 accepts and reads the filter RAM, stage 1 computes     |
// |             and loads the response register.                              |
// | Options   : CFU_ACC_SAT_EN - saturating accumulation, sticky per-acc       |
// |             saturation flags, op 7 (RDS) reads the flag.                   |
// | Revision  : 1.0  initial pipelined release                                 |
// +----------------------------------------------------------------------------+
module cfu_simd_mac_pipe
  import cfu_simd_pkg::*;
#(
  parameter int FILT_DEPTH    = 512,
  parameter int ADDR_W        = $clog2(FILT_DEPTH),
  parameter int NUM_ACC       = 4,
  // Must lie in 20..32 so the 20-bit lane sum fits and readback fits 32 bits.
  parameter int ACC_W         = 32,
  parameter int IN_OFFSET_RST = 128
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0
);

  // ---------------------------------------------------------------- state
  logic                    r_s1_valid;
  s1_cmd_t                 r_s1;
  logic [31:0]             r_f;
  logic [31:0]             r_filt [FILT_DEPTH];
  logic signed [OFF_W-1:0] r_off;
  logic signed [ACC_W-1:0] r_acc [NUM_ACC];
  logic                    r_rsp_valid;
  logic [31:0]             r_rsp_data;

  // ---------------------------------------------------------------- stage 0
  logic [OP_W-1:0]   w_cmd_op;
  logic [2:0]        w_cmd_sel;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_wr_in_range;
  logic              w_rd_in_range;
  logic              w_accept;
  logic              w_s1_fire;

  assign w_cmd_op  = cmd_payload_function_id[9:3];
  assign w_cmd_sel = acc_sel(cmd_payload_function_id[2:0], NUM_ACC);
  assign w_wr_addr = cmd_payload_inputs_0[ADDR_W-1:0];
  assign w_rd_addr = cmd_payload_inputs_1[ADDR_W-1:0];

  // Stage 1 retires whenever the response register is empty or being taken;
  // a new command may enter whenever stage 1 is empty or retiring.
  assign w_s1_fire = r_s1_valid && (!r_rsp_valid || rsp_ready);
  assign cmd_ready = !r_s1_valid || !r_rsp_valid || rsp_ready;
  assign w_accept  = cmd_valid && cmd_ready;

  if ((1 << ADDR_W) == FILT_DEPTH) begin : g_addr_pow2
    assign w_wr_in_range = 1'b1;
    assign w_rd_in_range = 1'b1;
  end else begin : g_addr_bounded
    assign w_wr_in_range = ({1'b0, w_wr_addr} < (ADDR_W+1)'(FILT_DEPTH));
    assign w_rd_in_range = ({1'b0, w_rd_addr} < (ADDR_W+1)'(FILT_DEPTH));
  end

  // Filter RAM: WRF writes on accept; every accepted command reads F[B] so the
  // word is ready for stage 1. A write at edge t is visible to a read at t+1.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      if ((w_cmd_op == OP_WRF) && w_wr_in_range) begin
        r_filt[w_wr_addr] <= cmd_payload_inputs_1;
      end
      r_f <= w_rd_in_range ? r_filt[w_rd_addr] : '0;
    end
  end

  // Stage-1 command register: loads on accept, empties when it retires unrefilled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1       <= s1_cmd_t'{op: w_cmd_op, sel: w_cmd_sel, a: cmd_payload_inputs_0};
    end else if (w_s1_fire) begin
      r_s1_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- stage 1
  logic signed [SUM_W-1:0] w_dot;
  logic signed [ACC_W-1:0] w_dot_ext;
  logic signed [ACC_W-1:0] w_acc_cur;
  logic signed [ACC_W-1:0] w_acc_new;
  logic                    w_is_mac;
  logic [31:0]             w_rsp;

  assign w_is_mac  = (r_s1.op == OP_MAC4) || (r_s1.op == OP_MAC1);
  assign w_dot_ext = ACC_W'(w_dot);

  cfu_dot4 u_dot4 (
    .a           (r_s1.a),
    .f           (r_f),
    .off         (r_off),
    .single_lane (r_s1.op == OP_MAC1),
    .sum         (w_dot)
  );

  // Select the accumulator addressed by the stage-1 command.
  always_comb begin
    w_acc_cur = '0;
    for (int i = 0; i < NUM_ACC; i++) begin
      if (int'(r_s1.sel) == i) w_acc_cur = r_acc[i];
    end
  end

`ifdef CFU_ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] c_acc_max = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] c_acc_min = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W:0] w_acc_wide;
  logic                  w_ovf;
  logic [NUM_ACC-1:0]    r_sat;
  logic                  w_sat_cur;

  // One extra bit catches overflow; clip towards the sign of the true sum.
  always_comb begin
    w_acc_wide = (ACC_W+1)'(w_acc_cur) + (ACC_W+1)'(w_dot_ext);
    w_ovf      = (w_acc_wide[ACC_W] != w_acc_wide[ACC_W-1]);
    if (w_ovf) begin
      w_acc_new = w_acc_wide[ACC_W] ? c_acc_min : c_acc_max;
    end else begin
      w_acc_new = w_acc_wide[ACC_W-1:0];
    end
  end

  // Read back the sticky flag of the selected accumulator.
  always_comb begin
    w_sat_cur = 1'b0;
    for (int i = 0; i < NUM_ACC; i++) begin
      if (int'(r_s1.sel) == i) w_sat_cur = r_sat[i];
    end
  end

  // Sticky saturation flags: set on a clipping MAC, cleared by CLR.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sat <= '0;
    end else if (w_s1_fire) begin
      for (int i = 0; i < NUM_ACC; i++) begin
        if (int'(r_s1.sel) == i) begin
          if (w_is_mac && w_ovf) r_sat[i] <= 1'b1;
          else if (r_s1.op == OP_CLR) r_sat[i] <= 1'b0;
        end
      end
    end
  end
`else
  // Plain two's-complement accumulation, wrapping modulo 2^ACC_W.
  always_comb begin
    w_acc_new = w_acc_cur + w_dot_ext;
  end
`endif

  // Response value for the retiring command.
  always_comb begin
    w_rsp = '0;
    case (r_s1.op)
      OP_MAC4, OP_MAC1: w_rsp = 32'(w_acc_new);
      OP_SETO:          w_rsp = 32'(r_off);
      OP_RDA:           w_rsp = 32'(w_acc_cur);
`ifdef CFU_ACC_SAT_EN
      OP_RDS:           w_rsp = {31'b0, w_sat_cur};
`endif
      default:          w_rsp = '0;
    endcase
  end

  // Accumulator and offset updates happen only when stage 1 retires, so
  // back-to-back commands chain and SETO only affects later commands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_ACC; i++) r_acc[i] <= '0;
      r_off <= OFF_W'(IN_OFFSET_RST);
    end else if (w_s1_fire) begin
      if (r_s1.op == OP_SETO) r_off <= r_s1.a[OFF_W-1:0];
      for (int i = 0; i < NUM_ACC; i++) begin
        if (int'(r_s1.sel) == i) begin
          if (w_is_mac) r_acc[i] <= w_acc_new;
          else if (r_s1.op == OP_CLR) r_acc[i] <= '0;
        end
      end
    end
  end

  // Response register: loads on retire, holds while stalled, clears when taken.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else if (w_s1_fire) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= w_rsp;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid             = r_rsp_valid;
  assign rsp_payload_outputs_0 = r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_cfu_simd_mac_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_cfu_simd_mac_pipe                                           |
// | Brief     : Directed self-checking bench for cfu_simd_mac_pipe.            |
// | Options   : CFU_ACC_SAT_EN selects the saturating expectations.            |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module tb_cfu_simd_mac_pipe;
  import cfu_simd_pkg::*;

`ifdef CFU_ACC_SAT_EN
  localparam logic [31:0] EXP_EDGE = 32'h7FFF_FFFF;
  localparam logic [31:0] EXP_RDS  = 32'd1;
`else
  localparam logic [31:0] EXP_EDGE = 32'h8000_0180;
  localparam logic [31:0] EXP_RDS  = 32'd0;
`endif

  logic        clk       = 1'b0;
  logic        reset_n   = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  fid       = '0;
  logic [31:0] in0       = '0;
  logic [31:0] in1       = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_acc;
  int first_acc;
  int spin;

  logic [31:0] rq [$];
  int          rc [$];

  cfu_simd_mac_pipe dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (fid),
    .cmd_payload_inputs_0    (in0),
    .cmd_payload_inputs_1    (in1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // A response seen valid&&ready at the falling edge is taken at the next rising edge.
  always @(negedge clk) begin
    if (reset_n && rsp_valid && rsp_ready) begin
      rq.push_back(rsp_data);
      rc.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one command and hold it until accepted; returns at posedge+1.
  task automatic send(input logic [6:0] op, input logic [2:0] sel,
                      input logic [31:0] a, input logic [31:0] b);
    int  n    = 0;
    bit  done = 0;
    cmd_valid = 1'b1;
    fid       = {op, sel};
    in0       = a;
    in1       = b;
    while (!done) begin
      @(negedge clk);
      if (cmd_ready) begin
        last_acc = cyc;
        done     = 1;
      end else if (++n > 50) begin
        errors++;
        $error("FAIL send_timeout observed=not_accepted expected=accepted");
        done = 1;
      end
      step();
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input string tag);
    int k = 0;
    while (rq.size() < n && k < 200) begin
      step();
      k++;
    end
    check({tag, "_cnt"}, 32'(rq.size()), 32'(n));
  endtask

  task automatic txn(input logic [6:0] op, input logic [2:0] sel,
                     input logic [31:0] a, input logic [31:0] b,
                     input string tag, input logic [31:0] exp);
    rq.delete();
    rc.delete();
    send(op, sel, a, b);
    wait_rsp(1, tag);
    check(tag, (rq.size() > 0) ? rq[0] : 32'hxxxx_xxxx, exp);
  endtask

  initial begin
    // ---- reset
    reset_n = 1'b0;
    repeat (3) step();
    check("rst_hold_valid", {31'b0, rsp_valid}, 32'd0);
    reset_n = 1'b1;
    step();
    check("rst_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_ready", {31'b0, cmd_ready}, 32'd1);
    check("rst_data", rsp_data, 32'd0);
    for (int s = 0; s < 4; s++) txn(OP_RDA, 3'(s), 32'd0, 32'd0, $sformatf("rst_rda%0d", s), 32'd0);

    // ---- offset reset value and two-cycle latency
    txn(OP_SETO, 3'd0, 32'd0, 32'd0, "rst_off", 32'd128);
    check("latency", (rc.size() > 0) ? 32'(rc[0] - last_acc) : 32'hxxxx_xxxx, 32'd2);
    txn(OP_SETO, 3'd0, 32'd128, 32'd0, "seto_restore", 32'd0);

    // ---- WRF then MAC4 on the very next cycle, chained MAC4, untouched acc 0
    rq.delete();
    rc.delete();
    send(OP_WRF, 3'd0, 32'd5, 32'h01FF_0203);
    send(OP_MAC4, 3'd1, 32'h0, 32'd5);
    send(OP_MAC4, 3'd1, 32'h0, 32'd5);
    send(OP_RDA, 3'd0, 32'h0, 32'd0);
    wait_rsp(4, "hazard");
    if (rq.size() >= 4) begin
      check("wrf_rsp", rq[0], 32'd0);
      check("mac4_first", rq[1], 32'd640);
      check("mac4_chain", rq[2], 32'd1280);
      check("rda0_clean", rq[3], 32'd0);
    end

    // ---- MAC1 with offset 0 then -1; select 6 maps to acc 2
    txn(OP_SETO, 3'd0, 32'd0, 32'd0, "seto_old128", 32'd128);
    txn(OP_MAC1, 3'd2, 32'h7F, 32'd5, "mac1_off0", 32'd381);
    txn(OP_SETO, 3'd0, 32'h1FF, 32'd0, "seto_old0", 32'd0);
    txn(OP_MAC1, 3'd2, 32'h7F, 32'd5, "mac1_offm1", 32'd759);
    txn(OP_RDA, 3'd6, 32'd0, 32'd0, "rda_sel6", 32'd759);
    // lanes of A differ: (0*3)+(1*2)+(2*-1)+(3*1) = 3
    txn(OP_MAC4, 3'd2, 32'h0403_0201, 32'd5, "mac4_lanes", 32'd762);

    // ---- streaming: 8 back-to-back MAC4 on acc 0, each adds -5
    rq.delete();
    rc.delete();
    for (int k = 0; k < 8; k++) begin
      send(OP_MAC4, 3'd0, 32'h0, 32'd5);
      if (k == 0) first_acc = last_acc;
    end
    check("stream_accept_span", 32'(last_acc - first_acc), 32'd7);
    wait_rsp(8, "stream");
    for (int k = 0; k < 8 && k < rq.size(); k++)
      check($sformatf("stream_val%0d", k), rq[k], 32'(-5 * (k + 1)));
    for (int k = 1; k < 8 && k < rc.size(); k++)
      check($sformatf("stream_gap%0d", k), 32'(rc[k] - rc[k-1]), 32'd1);

    // ---- stall: response not taken, pipeline fills after two accepts
    rq.delete();
    rc.delete();
    rsp_ready = 1'b0;
    send(OP_MAC4, 3'd0, 32'h0, 32'd5);
    send(OP_MAC4, 3'd0, 32'h0, 32'd5);
    @(negedge clk);
    check("stall_ready0", {31'b0, cmd_ready}, 32'd0);
    check("stall_valid", {31'b0, rsp_valid}, 32'd1);
    check("stall_data", rsp_data, 32'hFFFF_FFD3);
    step();
    @(negedge clk);
    check("stall_hold_ready", {31'b0, cmd_ready}, 32'd0);
    check("stall_hold_data", rsp_data, 32'hFFFF_FFD3);
    step();
    rsp_ready = 1'b1;
    send(OP_MAC4, 3'd0, 32'h0, 32'd5);
    send(OP_MAC4, 3'd0, 32'h0, 32'd5);
    wait_rsp(4, "stall");
    for (int k = 0; k < 4 && k < rq.size(); k++)
      check($sformatf("stall_order%0d", k), rq[k], 32'(-45 - 5 * k));

    // ---- drive acc 3 to 0x7FFFFF00, then push it over the top
    txn(OP_SETO, 3'd0, 32'h100, 32'd0, "seto_oldm1", 32'hFFFF_FFFF);
    txn(OP_WRF, 3'd0, 32'd6, 32'h8080_8080, "wrf6", 32'd0);
    rq.delete();
    rc.delete();
    for (int k = 0; k < 10922; k++) send(OP_MAC4, 3'd3, 32'h8080_8080, 32'd6);
    send(OP_MAC4, 3'd3, 32'h7E02_0280, 32'd6);
    wait_rsp(10923, "bulk");
    if (rq.size() > 0) begin
      check("bulk_first", rq[0], 32'd196608);
      check("bulk_last", rq[rq.size()-1], 32'h7FFF_FF00);
    end
    txn(OP_SETO, 3'd0, 32'd128, 32'd0, "seto_oldm256", 32'hFFFF_FF00);
    txn(OP_MAC4, 3'd3, 32'h0, 32'd5, "acc_edge", EXP_EDGE);
    txn(OP_RDS, 3'd3, 32'h0, 32'd0, "rds_after_edge", EXP_RDS);
    txn(OP_CLR, 3'd3, 32'h0, 32'd0, "clr3", 32'd0);
    txn(OP_RDS, 3'd3, 32'h0, 32'd0, "rds_after_clr", 32'd0);
    txn(OP_RDA, 3'd3, 32'h0, 32'd0, "rda3_cleared", 32'd0);
    txn(7'd9, 3'd0, 32'h0, 32'd5, "op9", 32'd0);
    txn(OP_RDA, 3'd0, 32'h0, 32'd0, "rda0_kept", 32'hFFFF_FFC4);

    // ---- reset while a response is stalled
    rq.delete();
    rc.delete();
    rsp_ready = 1'b0;
    send(OP_MAC4, 3'd1, 32'h0, 32'd5);
    spin = 0;
    while (!rsp_valid && spin < 20) begin
      step();
      spin++;
    end
    check("pre_rst_valid", {31'b0, rsp_valid}, 32'd1);
    check("pre_rst_data", rsp_data, 32'd1920);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_async_data", rsp_data, 32'd0);
    step();
    reset_n   = 1'b1;
    rsp_ready = 1'b1;
    repeat (5) step();
    check("rst_no_rsp", 32'(rq.size()), 32'd0);
    txn(OP_RDA, 3'd1, 32'h0, 32'd0, "rst_acc1", 32'd0);
    txn(OP_RDA, 3'd2, 32'h0, 32'd0, "rst_acc2", 32'd0);
    txn(OP_SETO, 3'd0, 32'h0, 32'd0, "rst_off2", 32'd128);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
